// File: rtl/alu_muldiv_seq.sv
// Sequences the shared ALU through unsigned shift-add multiply and restoring divide.
// Latency: 33 cycles from accepted start to the done pulse; divide-by-zero finishes in 1.
// No backpressure: start is taken only when idle, and the caller stalls while busy is high.
module alu_muldiv_seq #(
    parameter int instruction_width = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         op,
    input  logic [instruction_width-1:0] src_a,
    input  logic [instruction_width-1:0] src_b,
    input  logic [instruction_width-1:0] alu_y,
    output logic [instruction_width-1:0] alu_a,
    output logic [instruction_width-1:0] alu_b,
    output logic [3:0]                   alu_ctr,
    output logic                         busy,
    output logic                         done,
    output logic [instruction_width-1:0] hi,
    output logic [instruction_width-1:0] lo
);
    localparam int cnt_w = $clog2(instruction_width);
    localparam logic [cnt_w-1:0] last_count = cnt_w'(instruction_width - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CTR_NOP = 4'b0000;
    localparam logic [3:0] CTR_ADD = 4'b0010;
    localparam logic [3:0] CTR_SUB = 4'b0110;

    logic [1:0]                   state;
    logic [cnt_w-1:0]             count;
    logic [instruction_width-1:0] m_r;
    logic                         op_r;

    // Divide step: partial remainder shifted left with the next dividend bit.
    logic [instruction_width-1:0] div_t;
    logic                         div_take;
    logic                         mul_carry;

    assign div_t     = {hi[instruction_width-2:0], lo[instruction_width-1]};
    assign div_take  = hi[instruction_width-1] | (div_t >= m_r);
    assign mul_carry = (alu_y < hi);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctr = CTR_NOP;
        if (state == S_CALC) begin
            alu_b = m_r;
            if (op_r) begin
                alu_a   = div_t;
                alu_ctr = CTR_SUB;
            end else begin
                alu_a   = hi;
                alu_ctr = CTR_ADD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            m_r   <= '0;
            op_r  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        count <= '0;
                        if (op && (src_b == '0)) begin
                            hi    <= src_a;
                            lo    <= '1;
                            state <= S_DONE;
                        end else begin
                            hi    <= '0;
                            m_r   <= op ? src_b : src_a;
                            lo    <= op ? src_a : src_b;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (op_r) begin
                        if (div_take) begin
                            hi <= alu_y;
                            lo <= {lo[instruction_width-2:0], 1'b1};
                        end else begin
                            hi <= div_t;
                            lo <= {lo[instruction_width-2:0], 1'b0};
                        end
                    end else if (lo[0]) begin
                        hi <= {mul_carry, alu_y[instruction_width-1:1]};
                        lo <= {alu_y[0], lo[instruction_width-1:1]};
                    end else begin
                        hi <= {1'b0, hi[instruction_width-1:1]};
                        lo <= {hi[0], lo[instruction_width-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == last_count) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: an adder/subtractor ALU model closes the loop, and results are
// compared against plain 64-bit multiply and integer divide/modulo.
module tb_alu_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] src_a, src_b, alu_y, alu_a, alu_b, hi, lo;
    logic [3:0]   alu_ctr;
    logic         busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_y = '0;
        case (alu_ctr)
            4'b0010: alu_y = alu_a + alu_b;
            4'b0110: alu_y = alu_a - alu_b;
            default: alu_y = '0;
        endcase
    end

    alu_muldiv_seq #(.instruction_width(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .alu_y(alu_y),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    function automatic void ref_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] eh, output logic [W-1:0] el,
                                   output int elat);
        logic [2*W-1:0] p;
        if (!o) begin
            p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            eh   = p[2*W-1:W];
            el   = p[W-1:0];
            elat = 33;
        end else if (b == '0) begin
            eh   = a;
            el   = '1;
            elat = 1;
        end else begin
            eh   = a % b;
            el   = a / b;
            elat = 33;
        end
    endfunction

    // Runs one operation and gathers observations; inject_at > 0 pulses a stray start there.
    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inject_at,
                         output logic [W-1:0] rh, output logic [W-1:0] rl,
                         output int lat, output int bad_cycles, output logic tail_ok);
        logic [3:0] exp_ctr;
        exp_ctr    = o ? 4'b0110 : 4'b0010;
        lat        = -1;
        bad_cycles = 0;
        tail_ok    = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy || alu_ctr !== exp_ctr) bad_cycles++;
            if (k == inject_at) begin
                start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom | 32'd1;
            end
        end
        start = 1'b0;
        rh = hi;
        rl = lo;
        if (busy !== 1'b1 || alu_ctr !== 4'b0000) tail_ok = 1'b0;
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) tail_ok = 1'b0;
        repeat (2) @(negedge clk);
        if (hi !== rh || lo !== rl) tail_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (alu_ctr !== 4'b0000 || alu_a !== '0 || alu_b !== '0) begin
            errors++; $display("FAIL reset_alu got ctr=%b a=%h b=%h exp 0/0/0", alu_ctr, alu_a, alu_b);
        end
        rst = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int inject_at);
        logic [W-1:0] rh, rl, eh, el;
        int lat, elat, bad;
        logic tail;
        ref_op(o, a, b, eh, el, elat);
        do_op(o, a, b, inject_at, rh, rl, lat, bad, tail);
        checks++; if (rl !== el) begin errors++; $display("FAIL %s_lo got=%h exp=%h", name, rl, el); end
        checks++; if (rh !== eh) begin errors++; $display("FAIL %s_hi got=%h exp=%h", name, rh, eh); end
        checks++; if (lat != elat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, elat); end
        checks++; if (bad != 0) begin errors++; $display("FAIL %s_calc_ctr bad_cycles=%0d exp=0", name, bad); end
        checks++; if (tail !== 1'b1) begin errors++; $display("FAIL %s_done_pulse_hold got=%b exp=1", name, tail); end
    endtask

    task automatic test_multiply;
        run_and_check("mul_7x6", 1'b0, 32'd7, 32'd6, 0);
        run_and_check("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_divide;
        run_and_check("div_100_7", 1'b1, 32'd100, 32'd7, 0);
        run_and_check("div_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
        run_and_check("div_3_10", 1'b1, 32'd3, 32'd10, 0);
        run_and_check("div_big", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    endtask

    task automatic test_div_zero;
        run_and_check("div_5_0", 1'b1, 32'd5, 32'd0, 0);
    endtask

    task automatic test_start_ignored;
        run_and_check("mul_stray_start", 1'b0, 32'h0001_2345, 32'h0000_BEEF, 5);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; op = 1'b1; src_a = 32'd1000; src_b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        checks++; if (hi !== '0 || lo !== '0) begin
            errors++; $display("FAIL rst_mid_hilo got hi=%h lo=%h exp 0/0", hi, lo);
        end
        rst = 1'b0;
        run_and_check("mul_9x9_after_rst", 1'b0, 32'd9, 32'd9, 0);
    endtask

    task automatic test_random;
        logic         o;
        logic [W-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = (o && i % 3 == 0) ? 32'd0 : 32'd1;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (i % 5 == 0) a = 32'($urandom_range(0, 255));
            run_and_check($sformatf("rand%0d_%s", i, o ? "div" : "mul"), o, a, b, 0);
        end
    endtask

    initial begin
        test_reset;
        test_multiply;
        test_divide;
        test_div_zero;
        test_start_ignored;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle controller that sequences the shared 32-bit ALU to perform unsigned multiply (shift-add) and unsigned divide (restoring).
- Sits beside the ALU in the single-cycle CPU's execute stage. Drives the ALU's a/b/alu_ctr inputs and consumes its y result.
- Exposes a start/busy/done handshake to the main control unit, which stalls the PC while busy=1.

Parameters:
instruction_width, 32, operand/result width; iteration count equals instruction_width; counter width is clog2(instruction_width).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  1  0 = multiply, 1 = divide; sampled with start
src_a  input  instruction_width  multiplicand or dividend
src_b  input  instruction_width  multiplier or divisor
alu_y  input  instruction_width  result from the ALU y output
alu_a  output  instruction_width  to the ALU a input
alu_b  output  instruction_width  to the ALU b input
alu_ctr  output  4  to the ALU alu_ctr input
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
hi  output  instruction_width  multiply: product[63:32]; divide: remainder
lo  output  instruction_width  multiply: product[31:0]; divide: quotient

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high and overrides everything, including mid-operation.
- Reset values: state=IDLE, count=0, busy=0, done=0, hi=0, lo=0, internal operand register M=0, op_r=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE with start=1 and divide-by-zero (op=1, src_b=0): hi<=src_a, lo<=all ones, go to DONE. No iterations.
  - IDLE with start=1 otherwise: latch op_r<=op, M<=src_b (mul: multiplicand src_a goes to M, multiplier src_b goes to lo; see below), hi<=0, count<=0, go to CALC.
    - Multiply load: M<=src_a, lo<=src_b.
    - Divide load: M<=src_b, lo<=src_a.
  - CALC: one iteration per cycle, count increments. After the iteration where count==instruction_width-1, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- busy: 1 in CALC and DONE, 0 in IDLE.
- start: ignored while busy=1. hi/lo hold their final values until the next accepted start.
- Latency: start sampled at edge E0; iterations occur at E1..E32; done=1 in the cycle after E32.
  - Divide-by-zero: done=1 in the cycle after E0.
- ALU drive:
  - CALC, multiply: alu_a=hi, alu_b=M, alu_ctr=4'b0010 (add).
  - CALC, divide: alu_a=T, alu_b=M, alu_ctr=4'b0110 (subtract).
  - IDLE/DONE: alu_a=0, alu_b=0, alu_ctr=4'b0000. Outputs are combinational from state and registers.
- Multiply iteration:
  - If lo[0]=1: c=(alu_y<hi) unsigned carry detect; hi<={c,alu_y[31:1]}; lo<={alu_y[0],lo[31:1]}.
  - Else: hi<={1'b0,hi[31:1]}; lo<={hi[0],lo[31:1]}.
- Divide iteration:
  - T={hi[30:0],lo[31]}; msb=hi[31].
  - If msb=1 or T>=M (unsigned): hi<=alu_y; lo<={lo[30:0],1'b1}.
  - Else: hi<=T; lo<={lo[30:0],1'b0}.
- Arithmetic width: all values are unsigned and mod 2^instruction_width except the internal 33-bit carry/msb terms. The ALU's zero output is not used.

Test Plan:
- Multiply 7×6 (start at E0): busy=1 for E0..E32, done pulses in the cycle after E32, hi=0x00000000, lo=0x0000002A; alu_ctr=0010 throughout CALC.
- Multiply 0xFFFFFFFF×0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 (exercises carry out of every add).
- Divide 100/7: lo=14, hi=2. Divide 0xFFFFFFFF/1: lo=0xFFFFFFFF, hi=0. Divide 3/10: lo=0, hi=3. alu_ctr=0110 throughout CALC.
- Divide 5/0: done one cycle after start, lo=0xFFFFFFFF, hi=5, alu_ctr stays 0000.
- Start pulsed at E5 during a multiply, with different operands: ignored; the original result is unchanged and done still follows E32.
- rst asserted at E10 of a divide: next cycle state=IDLE, busy=0, done=0, hi=lo=0. A new start after rst deasserts completes correctly with 9×9 → lo=81.
